stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Sequencing controller and time base for the stopwatch display path. Accepts single-cycle button pulses (start/stop, lap, clear) and a 1 Hz tick, and runs the mode state machine. Maintains the live MM:SS BCD count and the lap snapshot, and drives the 4-digit BCD word to the per-digit decoders and the display scanner. Replaces the separate per-button toggle FSMs and the lap-aware counter with one arbitrated controller.

## Interface
- `MIN_LIMIT`, default 59: highest minute value, 1–99. The count wraps or stops after `MIN_LIMIT`:59.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  1 Hz enable, one `clk` cycle wide.
- `start_pb`  in  1  debounced one-pulse start/stop request, one cycle wide.
- `lap_pb`  in  1  debounced one-pulse lap request, one cycle wide.
- `clr_pb`  in  1  debounced one-pulse clear request, one cycle wide.
- `state`  out  3  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3, LAP_PAUSE=4.
- `count_en`  out  1  high in RUN and LAP.
- `lap_active`  out  1  high in LAP and LAP_PAUSE.
- `live_bcd`  out  16  {ten_m, one_m, ten_s, one_s}, the live count.
- `disp_bcd`  out  16  the lap register when `lap_active`, else `live_bcd`.
- `wrap`  out  1  one-cycle pulse when the count leaves `MIN_LIMIT`:59.

## Operation
- Request priority within one cycle: clr > start > lap. A lower-priority request in the same cycle is dropped, not queued.
- `clr_pb` in any state: go to IDLE, zero the live count, zero the lap register.
- IDLE: start → RUN. Lap is ignored.
- RUN: start → PAUSE. Lap → LAP, and the lap register captures the live count.
- PAUSE: start → RUN. Lap is ignored.
- LAP: lap → RUN, releasing the freeze. Start → LAP_PAUSE.
- LAP_PAUSE: start → LAP. Lap → PAUSE.
- Counting: on `tick` while the current registered state is RUN or LAP, increment BCD.
  - one_s runs 0–9.
  - ten_s runs 0–5 and carries at 59 s.
  - one_m runs 0–9.
  - ten_m runs 0–9.
  - Minutes never exceed `MIN_LIMIT`.
- Digits are always valid BCD. Minute value = ten_m*10 + one_m.
- At `MIN_LIMIT`:59 plus a tick: count becomes 00:00 and `wrap` pulses. The FSM state is unchanged. (Default build; see Configuration.)
- The lap register updates only on entry to LAP from RUN. Re-entry to LAP from LAP_PAUSE keeps the old snapshot.

## Timing
- All outputs are registered and update on the first `clk` edge after the input event. Latency is 1 cycle.
- Reset values: `state`=IDLE, `count_en`=0, `lap_active`=0, `live_bcd`=0, `disp_bcd`=0, `wrap`=0, lap register=0.
- Tick in the same cycle as a start that leaves RUN: the tick is counted, because state is sampled before the transition.
- Tick in the same cycle as a start that enters RUN from PAUSE: the tick is not counted.
- Tick in the same cycle as lap capture from RUN: the capture takes the pre-increment value. The live count still increments.
- Tick in the same cycle as clr: the count ends at 00:00 and `wrap` is suppressed.
- `rst` asserted mid-count: outputs return to reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Request pulses wider than one cycle act once per asserted cycle. Upstream one-pulse logic guarantees one-cycle pulses.

## Configuration
- `STOPWATCH_CTRL_AUTOSTOP_EN` undefined (default): the count wraps at `MIN_LIMIT`:59 → 00:00 with a `wrap` pulse, as above.
- `STOPWATCH_CTRL_AUTOSTOP_EN` defined:
  - At `MIN_LIMIT`:59 with a qualifying tick, the count holds at `MIN_LIMIT`:59.
  - The FSM moves RUN→PAUSE or LAP→LAP_PAUSE on that edge.
  - `wrap` pulses once.
  - `start_pb` is ignored in PAUSE or LAP_PAUSE while the count equals `MIN_LIMIT`:59. Only `clr_pb` or `rst` exits.

## Test plan
- Reset, then start_pb, then 75 ticks → `state`=RUN, `live_bcd`=16'h0115, `count_en`=1.
- At 00:12 in RUN, lap_pb, then 5 ticks → `disp_bcd`=16'h0012, `live_bcd`=16'h0017, `lap_active`=1. Then lap_pb → `disp_bcd`=16'h0017.
- start_pb and lap_pb in the same cycle from RUN → `state`=PAUSE, lap register unchanged. clr_pb together with tick → IDLE and 16'h0000.
- `MIN_LIMIT`=2, count at 02:59, one tick → default build: 16'h0000 with a 1-cycle `wrap`. AUTOSTOP build: 16'h0259, `state`=PAUSE, and a following start_pb is ignored.
- `rst` pulsed at 00:33 in LAP_PAUSE → all outputs zero and IDLE on the same edge. A tick while in reset leaves `live_bcd`=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose:
//   Mode sequencer and MM:SS BCD time base for the stopwatch display path.
//   One arbitrated controller takes the start/stop, lap and clear button
//   pulses plus a 1 Hz tick. It keeps the live count and the lap snapshot,
//   and drives the 4-digit BCD word to the digit decoders and the scanner.
//
// Parameters:
//   MIN_LIMIT  highest minute value (1..99). The count tops out at MIN_LIMIT:59.
//
// Optional feature macro:
//   STOPWATCH_CTRL_AUTOSTOP_EN
//     undefined : at MIN_LIMIT:59 a tick wraps the count to 00:00 and pulses
//                 wrap. The state does not change.
//     defined   : at MIN_LIMIT:59 a tick holds the count and pulses wrap.
//                 The FSM drops from RUN to PAUSE, or from LAP to LAP_PAUSE.
//                 start is then ignored while paused at the limit.
//
// Ports:
//   clk         in   system clock (rising edge)
//   rst         in   asynchronous active-high reset
//   tick        in   1 Hz count enable, one clk wide
//   start_pb    in   start/stop request pulse
//   lap_pb      in   lap request pulse
//   clr_pb      in   clear request pulse
//   state       out  FSM state: IDLE=0 RUN=1 PAUSE=2 LAP=3 LAP_PAUSE=4
//   count_en    out  high in RUN and LAP
//   lap_active  out  high in LAP and LAP_PAUSE
//   live_bcd    out  {ten_m, one_m, ten_s, one_s} live count
//   disp_bcd    out  lap snapshot while lap_active, else the live count
//   wrap        out  one-cycle pulse when the count leaves MIN_LIMIT:59
//
// All outputs are registered. They update on the first clk edge after the
// input event.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int MIN_LIMIT = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_pb,
  input  logic        lap_pb,
  input  logic        clr_pb,
  output logic [2:0]  state,
  output logic        count_en,
  output logic        lap_active,
  output logic [15:0] live_bcd,
  output logic [15:0] disp_bcd,
  output logic        wrap
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PAUSE     = 3'd2,
    S_LAP       = 3'd3,
    S_LAP_PAUSE = 3'd4
  } state_t;

  // Minute limit split into its BCD digits, so the limit test compares digits.
  localparam logic [3:0] LIM_TEN = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONE = 4'(MIN_LIMIT % 10);

  state_t      state_q, state_d;
  logic [3:0]  one_s_q, one_s_d;
  logic [3:0]  ten_s_q, ten_s_d;
  logic [3:0]  one_m_q, one_m_d;
  logic [3:0]  ten_m_q, ten_m_d;
  logic [15:0] lap_q, lap_d;
  logic        count_en_q, count_en_d;
  logic        lap_active_q, lap_active_d;
  logic [15:0] disp_q, disp_d;
  logic        wrap_q, wrap_d;

  logic [15:0] live_q;
  logic [15:0] live_d;
  logic        counting;
  logic        at_limit;
  logic        adv;
  logic        limit_tick;
  logic        start_ok;

  assign live_q = {ten_m_q, one_m_q, ten_s_q, one_s_q};
  assign live_d = {ten_m_d, one_m_d, ten_s_d, one_s_d};

  // Counting follows the registered state, not the next state.
  // A tick that arrives with a start leaving RUN is therefore still counted.
  // A tick that arrives with a start entering RUN is not.
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);

  assign at_limit = (ten_m_q == LIM_TEN) && (one_m_q == LIM_ONE) &&
                    (ten_s_q == 4'd5)    && (one_s_q == 4'd9);

  // Clear takes priority over the tick, so a coincident tick is dropped.
  assign adv        = tick && counting && !clr_pb;
  assign limit_tick = adv && at_limit;

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
  // While parked at the limit, only clear or reset can leave the paused state.
  assign start_ok = start_pb &&
                    !(at_limit && ((state_q == S_PAUSE) || (state_q == S_LAP_PAUSE)));
`else
  assign start_ok = start_pb;
`endif

  // ---------------------------------------------------------------------
  // BCD time base
  // ---------------------------------------------------------------------
  always_comb begin
    one_s_d = one_s_q;
    ten_s_d = ten_s_q;
    one_m_d = one_m_q;
    ten_m_d = ten_m_q;
    wrap_d  = 1'b0;

    if (clr_pb) begin
      one_s_d = 4'd0;
      ten_s_d = 4'd0;
      one_m_d = 4'd0;
      ten_m_d = 4'd0;
    end else if (adv) begin
      if (at_limit) begin
        wrap_d = 1'b1;
`ifndef STOPWATCH_CTRL_AUTOSTOP_EN
        one_s_d = 4'd0;
        ten_s_d = 4'd0;
        one_m_d = 4'd0;
        ten_m_d = 4'd0;
`endif
      end else if (one_s_q != 4'd9) begin
        one_s_d = one_s_q + 4'd1;
      end else begin
        one_s_d = 4'd0;
        if (ten_s_q != 4'd5) begin
          ten_s_d = ten_s_q + 4'd1;
        end else begin
          ten_s_d = 4'd0;
          // The limit check above keeps the minutes at or below MIN_LIMIT,
          // so ten_m cannot pass 9 here.
          if (one_m_q != 4'd9) begin
            one_m_d = one_m_q + 4'd1;
          end else begin
            one_m_d = 4'd0;
            ten_m_d = ten_m_q + 4'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM and lap register
  // Request priority: clr > start > lap. A lower request is dropped.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;

    if (clr_pb) begin
      state_d = S_IDLE;
      lap_d   = 16'd0;
    end
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    // Reaching the limit overrides any button in the same cycle.
    else if (limit_tick) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_LAP_PAUSE;
    end
`endif
    else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) state_d = S_RUN;
        end
        S_RUN: begin
          if (start_ok) begin
            state_d = S_PAUSE;
          end else if (lap_pb) begin
            state_d = S_LAP;
            // Snapshot the pre-increment count, even with a coincident tick.
            lap_d   = live_q;
          end
        end
        S_PAUSE: begin
          if (start_ok) state_d = S_RUN;
        end
        S_LAP: begin
          if (start_ok)    state_d = S_LAP_PAUSE;
          else if (lap_pb) state_d = S_RUN;
        end
        S_LAP_PAUSE: begin
          // Entering LAP from here keeps the existing snapshot.
          if (start_ok)    state_d = S_LAP;
          else if (lap_pb) state_d = S_PAUSE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output register inputs are taken from next-state values.
  // This keeps every output aligned with the state it describes.
  always_comb begin
    count_en_d   = (state_d == S_RUN) || (state_d == S_LAP);
    lap_active_d = (state_d == S_LAP) || (state_d == S_LAP_PAUSE);
    disp_d       = lap_active_d ? lap_d : live_d;
  end

  // limit_tick has no other reader in the wrap-around build.
`ifndef STOPWATCH_CTRL_AUTOSTOP_EN
  logic unused_limit_tick;
  assign unused_limit_tick = limit_tick;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      one_s_q      <= 4'd0;
      ten_s_q      <= 4'd0;
      one_m_q      <= 4'd0;
      ten_m_q      <= 4'd0;
      lap_q        <= 16'd0;
      count_en_q   <= 1'b0;
      lap_active_q <= 1'b0;
      disp_q       <= 16'd0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      one_s_q      <= one_s_d;
      ten_s_q      <= ten_s_d;
      one_m_q      <= one_m_d;
      ten_m_q      <= ten_m_d;
      lap_q        <= lap_d;
      count_en_q   <= count_en_d;
      lap_active_q <= lap_active_d;
      disp_q       <= disp_d;
      wrap_q       <= wrap_d;
    end
  end

  assign state      = state_q;
  assign count_en   = count_en_q;
  assign lap_active = lap_active_q;
  assign live_bcd   = live_q;
  assign disp_bcd   = disp_q;
  assign wrap       = wrap_q;

endmodule
